// File: rtl/pipe_stage_elastic_pkg.sv
// Shared pipeline definitions: stage occupancy encodings and the NOP bubble word.
package pipe_stage_elastic_pkg;

    // Occupancy encoding, visible on occ so the hazard unit can decode it.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // All-zero instruction word decodes as sll $0,$0,0.
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clears on reset and sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;

    // Count up on inc until all-ones, then hold.
    always_ff @(negedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: main register plus one skid entry behind a
// valid/ready handshake, with flush-to-bubble and a back-pressure counter.
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int unsigned      WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
    parameter int unsigned      CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_xfer;
    logic             out_xfer;

    // Handshake flags depend only on registered state, never on the inputs.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occ       = state_q;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Next-state: flush overrides every handshake; main always shows BUBBLE when empty.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d = ST_BUSY;
                        main_d  = in_data;
                    end
                end
                ST_BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (in_xfer) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the skid can move forward.
                    if (out_xfer) begin
                        state_d = ST_BUSY;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    // Stage registers advance on the falling edge like the rest of the pipeline.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Back-pressure counter; flush does not touch it, reset does.
    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid && !out_ready),
        .q   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic with a queue-based scoreboard.
module tb_pipe_stage_elastic;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occ;
    logic [15:0] stall_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_data;
    logic [1:0]  s_occ;
    logic [2:0]  s_stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard: entries accepted but not yet consumed, head first.
    logic [31:0] sb[$];
    logic [15:0] exp_stall16 = 16'd0;
    logic [2:0]  exp_stall3  = 3'd0;
    logic [1:0]  exp_occ     = 2'd0;
    logic        exp_valid   = 1'b0;
    logic [31:0] exp_data    = 32'd0;
    logic        acc;

    pipe_stage_elastic #(
        .WIDTH (32),
        .CNT_W (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_elastic #(
        .WIDTH (32),
        .CNT_W (3)
    ) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_data   (in_data),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_data  (s_out_data),
        .occ       (s_occ),
        .stall_cnt (s_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle, update the scoreboard from pre-edge model state, then
    // wait for the falling edge and settle.
    task automatic drive(input logic iv, input logic [31:0] id, input logic ordy,
                         input logic fl, input logic rs);
        logic in_x;
        logic out_x;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        acc       = 1'b0;
        if (rs) begin
            sb.delete();
            exp_stall16 = 16'd0;
            exp_stall3  = 3'd0;
        end else begin
            if ((sb.size() > 0) && !ordy) begin
                if (exp_stall16 != 16'hffff) exp_stall16 = exp_stall16 + 16'd1;
                if (exp_stall3 != 3'd7) exp_stall3 = exp_stall3 + 3'd1;
            end
            in_x  = iv && (sb.size() < 2);
            out_x = ordy && (sb.size() > 0);
            if (fl) begin
                sb.delete();
            end else begin
                if (out_x) void'(sb.pop_front());
                if (in_x) begin
                    sb.push_back(id);
                    acc = 1'b1;
                end
            end
        end
        @(negedge clk);
        #1;
        exp_occ   = 2'(sb.size());
        exp_valid = (sb.size() != 0);
        exp_data  = (sb.size() != 0) ? sb[0] : 32'd0;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'hdead_beef, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (occ !== 2'd0) begin n_err++; $display("FAIL reset_occ got=%0d want=0", occ); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (out_data !== 32'd0) begin n_err++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
    endtask

    task automatic test_streaming();
        for (int i = 0; i <= 8; i++) begin
            drive(i < 8, 32'h1000 + 32'(i), 1'b1, 1'b0, 1'b0);
            if (i < 8) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== 32'h1000 + 32'(i)) begin
                    n_err++;
                    $display("FAIL stream_word[%0d] got=%b/%h want=1/%h", i, out_valid, out_data,
                             32'h1000 + 32'(i));
                end
            end
            n_cmp++;
            if (occ !== exp_occ || occ > 2'd1) begin
                n_err++; $display("FAIL stream_occ[%0d] got=%0d want=%0d", i, occ, exp_occ);
            end
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_back_pressure();
        int          ptr = 0;
        logic [15:0] base = exp_stall16;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 32'h2000 + 32'(ptr), 1'b0, 1'b0, 1'b0);
            if (acc) ptr++;
            n_cmp++;
            if (stall_cnt !== exp_stall16) begin
                n_err++; $display("FAIL bp_stall[%0d] got=%0d want=%0d", c, stall_cnt, exp_stall16);
            end
        end
        n_cmp++; if (ptr != 2) begin n_err++; $display("FAIL bp_accepted got=%0d want=2", ptr); end
        n_cmp++; if (occ !== 2'd2) begin n_err++; $display("FAIL bp_occ got=%0d want=2", occ); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        n_cmp++; if (stall_cnt !== base + 16'd2) begin
            n_err++; $display("FAIL bp_stall_total got=%0d want=%0d", stall_cnt, base + 16'd2);
        end
        // Release: at most 8 cycles to drain all three words.
        for (int c = 0; c < 8 && (ptr < 3 || sb.size() != 0); c++) begin
            drive(ptr < 3, 32'h2000 + 32'(ptr), 1'b1, 1'b0, 1'b0);
            if (acc) ptr++;
            n_cmp++;
            if (out_valid !== exp_valid || out_data !== exp_data || in_ready !== (exp_occ != 2'd2)) begin
                n_err++;
                $display("FAIL bp_release[%0d] got=%b/%h/%b want=%b/%h/%b", c, out_valid, out_data,
                         in_ready, exp_valid, exp_data, exp_occ != 2'd2);
            end
        end
        n_cmp++; if (ptr != 3 || sb.size() != 0) begin
            n_err++; $display("FAIL bp_complete got=%0d/%0d want=3/0", ptr, sb.size());
        end
    endtask

    task automatic test_flush();
        logic [15:0] base = exp_stall16;
        drive(1'b1, 32'h3000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h3001, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (occ !== 2'd2) begin n_err++; $display("FAIL flush_pre_occ got=%0d want=2", occ); end
        drive(1'b1, 32'h3002, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (occ !== 2'd0) begin n_err++; $display("FAIL flush_occ got=%0d want=0", occ); end
        n_cmp++; if (out_data !== 32'd0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_out got=%b/%h want=0/0", out_valid, out_data);
        end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (stall_cnt !== base + 16'd2) begin
            n_err++; $display("FAIL flush_stall got=%0d want=%0d", stall_cnt, base + 16'd2);
        end
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (out_valid !== 1'b0 || out_data !== 32'd0) begin
                n_err++; $display("FAIL flush_absent[%0d] got=%b/%h want=0/0", c, out_valid, out_data);
            end
        end
    endtask

    task automatic test_saturation();
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'h4000, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (s_stall_cnt !== exp_stall3) begin
                n_err++; $display("FAIL sat_cnt[%0d] got=%0d want=%0d", c, s_stall_cnt, exp_stall3);
            end
        end
        n_cmp++; if (s_stall_cnt !== 3'd7) begin n_err++; $display("FAIL sat_hold got=%0d want=7", s_stall_cnt); end
        n_cmp++; if (stall_cnt !== 16'd12) begin n_err++; $display("FAIL sat_wide got=%0d want=12", stall_cnt); end
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sat_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_soak();
        logic [31:0] offer = $urandom;
        logic        iv, ordy, fl, held;
        logic [31:0] prev_data;
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 10000; c++) begin
            iv        = ($urandom_range(0, 3) != 0);
            ordy      = ($urandom_range(0, 2) != 0);
            fl        = ($urandom_range(0, 99) == 0);
            held      = exp_valid && !ordy && !fl;
            prev_data = exp_data;
            drive(iv, offer, ordy, fl, 1'b0);
            if (acc) offer = $urandom;
            n_cmp++;
            if (out_data !== exp_data || out_valid !== exp_valid || occ !== exp_occ
                || in_ready !== (exp_occ != 2'd2) || stall_cnt !== exp_stall16) begin
                n_err++;
                $display("FAIL soak[%0d] got=%h/%b/%0d/%b/%0d want=%h/%b/%0d/%b/%0d", c, out_data,
                         out_valid, occ, in_ready, stall_cnt, exp_data, exp_valid, exp_occ,
                         exp_occ != 2'd2, exp_stall16);
            end
            if (held) begin
                n_cmp++;
                if (out_data !== prev_data) begin
                    n_err++; $display("FAIL soak_stable[%0d] got=%h want=%h", c, out_data, prev_data);
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        acc       = 1'b0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_saturation();
        test_soak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline stage register with valid/ready handshake, a one-entry skid buffer, synchronous flush with bubble insertion, and a saturating stall counter. It replaces the fixed, always-advancing per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Payload is an opaque flat bus packed by the instantiating stage, so one block serves every pipeline boundary. Stalls and hazard bubbles are expressed through the handshake instead of ad-hoc enable wires.

## Interface
- `WIDTH`, 32: payload width in bits (≥1).
- `BUBBLE`, `{WIDTH{1'b0}}`: payload presented whenever the stage holds nothing. All-zero decodes as `sll $0,$0,0`, i.e. a NOP.
- `CNT_W`, 16: stall-counter width (≥1).
- `clk`  in  1: stage clock. All state updates on the **falling** edge, matching the rest of the pipeline.
- `rst`  in  1: reset, synchronous, active-high, sampled on the falling edge.
- `flush`  in  1: synchronous discard of all held entries.
- `in_valid`  in  1: upstream offers `in_data`.
- `in_ready`  out  1: stage accepts this cycle. Registered, never combinational from `out_ready`.
- `in_data`  in  WIDTH: upstream payload.
- `out_valid`  out  1: `out_data` is a real entry.
- `out_ready`  in  1: downstream accepts this cycle.
- `out_data`  out  WIDTH: head payload, or `BUBBLE` when `out_valid`=0.
- `occ`  out  2: entries held (0, 1 or 2).
- `stall_cnt`  out  CNT_W: saturating count of back-pressure cycles.

## Operation
- **Handshake events**
  - Input transfer: `in_valid && in_ready` at an edge.
  - Output transfer: `out_valid && out_ready` at an edge.
  - Upstream may change `in_data` only after its transfer.
  - `out_data` is stable while `out_valid && !out_ready`.
- **Storage**: main register (drives `out_data`/`out_valid`) plus one skid register.
- **States** (encoding `occ`):
  - EMPTY=0, BUSY=1, FULL=2.
  - `in_ready` = (state != FULL).
  - `out_valid` = (state != EMPTY).
- **Transitions**, with priority `rst` > `flush` > handshake:
  - EMPTY, input transfer → BUSY, main←`in_data`.
  - BUSY, input and output transfer → BUSY, main←`in_data`.
  - BUSY, input only → FULL, skid←`in_data`.
  - BUSY, output only → EMPTY, main←`BUBBLE`.
  - FULL, output transfer → BUSY, main←skid. No input is possible since `in_ready`=0.
  - Any state, no transfer → hold.
- **Flush**
  - Forces EMPTY; main and skid ← `BUBBLE`.
  - An input offered in the flush cycle is dropped.
  - An output transfer in the flush cycle counts as completed, since downstream already consumed it.
- **Reset**
  - Same effect as flush, and also clears `stall_cnt` to 0.
  - Reset mid-operation discards everything held; no partial state survives.
- **Stall counter**
  - Increments on each edge where `out_valid && !out_ready`.
  - Holds at 2^CNT_W−1 and never wraps.
  - Unaffected by `flush`.

## Timing
- **Reset values**: `occ`=0, `out_valid`=0, `in_ready`=1, `out_data`=`BUBBLE`, `stall_cnt`=0.
- **Latency**: one edge from input transfer to `out_valid`=1, in EMPTY, or in BUSY with a simultaneous output transfer.
- **Throughput**: one transfer per cycle sustained while `out_ready`=1.
- **Back-pressure**: first stalled cycle still accepts one entry into the skid; `in_ready` drops after that edge.
- **Recovery**: `in_ready` rises one edge after the first output transfer out of FULL.
- **Flush**: `out_valid`=0 and `in_ready`=1 from the edge that samples `flush`.
- **Paths**: no combinational path from any input to any output.

## Structure
- State encodings `ST_EMPTY`/`ST_BUSY`/`ST_FULL` and the default NOP bubble constant go in the shared pipeline header, so the hazard unit can decode `occ`.
- One sub-module: `sat_counter` (parameter `W`; inputs `clk`, `rst`, `inc`; output `q`), reused for other performance counters.
- Stage-specific packing and unpacking of payload fields stays in the instantiating stage, not in this block.

## Test plan
- **Reset and idle**: reset asserted 2 edges → `occ`=0, `out_valid`=0, `in_ready`=1, `out_data`=0, `stall_cnt`=0.
- **Streaming**: 8 words 0x1000..0x1007 with `out_ready`=1 → each appears one edge later, in order, no gaps, `occ` stays ≤1.
- **Back-pressure**: 3 words offered with `out_ready`=0 → 2 accepted, `in_ready`=0, `occ`=2, `stall_cnt` increments each cycle. Release `out_ready` → words emerge in order, third accepted, no loss or duplication.
- **Flush**: flush in FULL with `in_valid`=1 → next edge `occ`=0, `out_data`=`BUBBLE`, offered word absent from output, `stall_cnt` retained.
- **Saturation**: `CNT_W`=3, `out_ready`=0 for 10 cycles with one entry held → `stall_cnt` = 7 and holds.
- **Randomized soak**: random `in_valid`/`out_ready`, 10k cycles, scoreboard → output sequence equals accepted input sequence, and `out_data` never changes while stalled.
